// File: rtl/tlv493_i2c_responder_if.sv
// ============================================================================
// tlv493_i2c_responder_if : open-drain I2C bus view shared by controller and target
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

interface tlv493_i2c_responder_if;
  logic scl;
  logic sda_in;
  logic sda_oe;

  modport master (output scl, output sda_in, input sda_oe);
  modport slave  (input scl, input sda_in, output sda_oe);
endinterface

`default_nettype wire

// File: rtl/tlv493_i2c_responder.sv
// ============================================================================
// tlv493_i2c_responder : I2C target emulating a TLV493D Hall sensor read/write map
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tlv493_i2c_responder #(
  parameter logic [6:0]  I2C_ADDR    = 7'h5E,
  parameter int          FILTER_LEN  = 3,
  parameter int          HOLD_CYCLES = 4,
  parameter logic [23:0] FACTORY     = 24'h000000
) (
  input  logic                   clock,
  input  logic                   reset_n,
  tlv493_i2c_responder_if.slave  bus,
  input  logic [11:0]            mag_x,
  input  logic [11:0]            mag_y,
  input  logic [11:0]            mag_z,
  input  logic [11:0]            temp,
  output logic [31:0]            config_data,
  output logic                   config_valid,
  output logic [1:0]             frm,
  output logic                   busy
);

  localparam int FCW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam int HCW = $clog2(HOLD_CYCLES + 1);

  typedef enum logic [2:0] {
    ST_IDLE, ST_ADDR, ST_ADDR_ACK, ST_WRITE_BYTE,
    ST_WRITE_ACK, ST_READ_BYTE, ST_READ_ACK, ST_IGNORE
  } state_t;

  logic [1:0] raw, filt, upd;
  assign raw = {bus.scl, bus.sda_in};

  // index 1 = SCL, index 0 = SDA; each: 2-FF synchronizer then stability filter
  for (genvar g = 0; g < 2; g++) begin : g_cond
    logic           s1, s2, lvl;
    logic [FCW-1:0] cnt;
    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        s1  <= 1'b1;
        s2  <= 1'b1;
        lvl <= 1'b1;
        cnt <= '0;
      end else begin
        s1 <= raw[g];
        s2 <= s1;
        if (s2 == lvl) begin
          cnt <= '0;
        end else if (cnt == FCW'(FILTER_LEN - 1)) begin
          lvl <= s2;
          cnt <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
    assign filt[g] = lvl;
    assign upd[g]  = (s2 != lvl) && (cnt == FCW'(FILTER_LEN - 1));
  end

  logic scl_f, sda_f, scl_rise, scl_fall, start_det, stop_det;
  assign scl_f     = filt[1];
  assign sda_f     = filt[0];
  assign scl_rise  = upd[1] & ~scl_f;
  assign scl_fall  = upd[1] &  scl_f;
  assign start_det = upd[0] &  sda_f & scl_f & ~upd[1];
  assign stop_det  = upd[0] & ~sda_f & scl_f & ~upd[1];

  state_t         state;
  logic [3:0]     bit_cnt, byte_idx;
  logic [2:0]     wr_idx;
  logic [7:0]     shreg, rd_data;
  logic [6:0]     tx;
  logic           rd_any, wr_any, nack, oe_want, sda_oe_q;
  logic [HCW-1:0] hold_cnt;
  logic [11:0]    sx, sy, sz, st;

  assign bus.sda_oe = sda_oe_q;

  always_comb begin
    rd_data = 8'hFF;
    case (byte_idx)
      4'd0:    rd_data = sx[11:4];
      4'd1:    rd_data = sy[11:4];
      4'd2:    rd_data = sz[11:4];
      4'd3:    rd_data = {st[11:8], frm, 2'b00};
      4'd4:    rd_data = {sx[3:0], sy[3:0]};
      4'd5:    rd_data = {4'b0011, sz[3:0]};
      4'd6:    rd_data = st[7:0];
      4'd7:    rd_data = FACTORY[23:16];
      4'd8:    rd_data = FACTORY[15:8];
      4'd9:    rd_data = FACTORY[7:0];
      default: rd_data = 8'hFF;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= ST_IDLE;
      bit_cnt      <= '0;
      byte_idx     <= '0;
      wr_idx       <= '0;
      shreg        <= '0;
      tx           <= '0;
      rd_any       <= 1'b0;
      wr_any       <= 1'b0;
      nack         <= 1'b0;
      oe_want      <= 1'b0;
      sda_oe_q     <= 1'b0;
      hold_cnt     <= '0;
      sx           <= '0;
      sy           <= '0;
      sz           <= '0;
      st           <= '0;
      config_data  <= '0;
      config_valid <= 1'b0;
      frm          <= '0;
      busy         <= 1'b0;
    end else begin
      config_valid <= 1'b0;
      // SDA only moves once the hold window after an SCL fall expires
      if (hold_cnt != '0) begin
        hold_cnt <= hold_cnt - 1'b1;
        if (hold_cnt == HCW'(1)) sda_oe_q <= oe_want;
      end
      if (start_det || stop_det) begin
        if (rd_any) frm <= frm + 2'd1;
        if (stop_det && wr_any) config_valid <= 1'b1;
        state    <= start_det ? ST_ADDR : ST_IDLE;
        bit_cnt  <= '0;
        byte_idx <= '0;
        wr_idx   <= '0;
        rd_any   <= 1'b0;
        wr_any   <= 1'b0;
        busy     <= 1'b0;
        oe_want  <= 1'b0;
      end else begin
        if (scl_fall) hold_cnt <= HCW'(HOLD_CYCLES);
        if (scl_rise) begin
          case (state)
            ST_ADDR, ST_WRITE_BYTE: begin
              shreg   <= {shreg[6:0], sda_f};
              bit_cnt <= bit_cnt + 1'b1;
            end
            ST_READ_BYTE: bit_cnt <= bit_cnt + 1'b1;
            ST_READ_ACK:  nack    <= sda_f;
            default: ;
          endcase
        end
        if (scl_fall) begin
          case (state)
            ST_ADDR: if (bit_cnt == 4'd8) begin
              if (shreg[7:1] == I2C_ADDR) begin
                state   <= ST_ADDR_ACK;
                oe_want <= 1'b1;
                busy    <= 1'b1;
                if (shreg[0]) begin
                  sx <= mag_x;
                  sy <= mag_y;
                  sz <= mag_z;
                  st <= temp;
                end
              end else begin
                state <= ST_IGNORE;
              end
            end
            ST_ADDR_ACK: begin
              bit_cnt <= '0;
              if (shreg[0]) begin
                state   <= ST_READ_BYTE;
                tx      <= rd_data[6:0];
                oe_want <= ~rd_data[7];
              end else begin
                state   <= ST_WRITE_BYTE;
                oe_want <= 1'b0;
              end
            end
            ST_WRITE_BYTE: if (bit_cnt == 4'd8) begin
              state   <= ST_WRITE_ACK;
              oe_want <= 1'b1;
              wr_any  <= 1'b1;
              if (!wr_idx[2]) begin
                config_data[{wr_idx[1:0], 3'b000} +: 8] <= shreg;
                wr_idx <= wr_idx + 1'b1;
              end
            end
            ST_WRITE_ACK: begin
              state   <= ST_WRITE_BYTE;
              bit_cnt <= '0;
              oe_want <= 1'b0;
            end
            ST_READ_BYTE: begin
              if (bit_cnt == 4'd8) begin
                state   <= ST_READ_ACK;
                oe_want <= 1'b0;
                rd_any  <= 1'b1;
                if (byte_idx != 4'hF) byte_idx <= byte_idx + 1'b1;
              end else begin
                oe_want <= ~tx[6];
                tx      <= {tx[5:0], 1'b0};
              end
            end
            ST_READ_ACK: begin
              if (!nack) begin
                state   <= ST_READ_BYTE;
                bit_cnt <= '0;
                tx      <= rd_data[6:0];
                oe_want <= ~rd_data[7];
              end else begin
                state   <= ST_IGNORE;
                busy    <= 1'b0;
                oe_want <= 1'b0;
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_tlv493_i2c_responder.sv
// ============================================================================
// tb_tlv493_i2c_responder : directed bus-master bench for tlv493_i2c_responder
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_tlv493_i2c_responder;
  localparam int Q = 15;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        sda_drv = 1'b1;
  logic [11:0] mag_x, mag_y, mag_z, temp;
  logic [31:0] config_data;
  logic        config_valid, busy;
  logic [1:0]  frm;

  int   n_tests = 0, n_fail = 0;
  int   oe_cycles = 0, cv_cycles = 0, oe_bad = 0;
  logic oe_prev = 1'b0;

  tlv493_i2c_responder_if bus();
  assign bus.sda_in = sda_drv & ~bus.sda_oe;

  always #5 clock = ~clock;

  tlv493_i2c_responder #(
    .I2C_ADDR(7'h5E), .FILTER_LEN(3), .HOLD_CYCLES(4), .FACTORY(24'h112233)
  ) dut (
    .clock(clock), .reset_n(reset_n), .bus(bus),
    .mag_x(mag_x), .mag_y(mag_y), .mag_z(mag_z), .temp(temp),
    .config_data(config_data), .config_valid(config_valid),
    .frm(frm), .busy(busy)
  );

  always @(negedge clock) begin
    if (bus.sda_oe) oe_cycles++;
    if (config_valid) cv_cycles++;
    if (reset_n && bus.scl && (bus.sda_oe !== oe_prev)) oe_bad++;
    oe_prev = bus.sda_oe;
  end

  task automatic wq(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic i2c_start();
    if (bus.scl == 1'b0) begin
      wq(Q); sda_drv = 1'b1; wq(Q); bus.scl = 1'b1; wq(Q);
    end
    sda_drv = 1'b0; wq(2*Q); bus.scl = 1'b0;
  endtask

  task automatic i2c_stop();
    wq(Q); sda_drv = 1'b0; wq(Q); bus.scl = 1'b1; wq(Q); sda_drv = 1'b1; wq(2*Q);
  endtask

  task automatic send_bit(input logic b);
    wq(Q); sda_drv = b; wq(Q); bus.scl = 1'b1; wq(2*Q); bus.scl = 1'b0;
  endtask

  task automatic recv_bit(output logic b);
    wq(Q); sda_drv = 1'b1; wq(Q); bus.scl = 1'b1; wq(Q); b = bus.sda_in; wq(Q); bus.scl = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] d, output logic ack);
    logic nb;
    for (int i = 7; i >= 0; i--) send_bit(d[i]);
    recv_bit(nb);
    ack = ~nb;
  endtask

  task automatic recv_byte(output logic [7:0] d, input logic ack);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      recv_bit(b);
      d[i] = b;
    end
    send_bit(~ack);
  endtask

  // ev holds the expected bytes left-justified, byte 0 in [87:80]
  task automatic do_read(input string tag, input int n, input logic [87:0] ev);
    logic       ack;
    logic [7:0] d;
    i2c_start();
    send_byte(8'hBD, ack);
    chk({tag, "_addr_ack"}, ack, 1);
    chk({tag, "_busy"}, busy, 1);
    for (int k = 0; k < n; k++) begin
      recv_byte(d, k < n - 1);
      chk($sformatf("%s_byte%0d", tag, k), d, ev[87 - 8*k -: 8]);
    end
    wq(10);
    chk({tag, "_busy_after_nack"}, busy, 0);
    i2c_stop();
  endtask

  initial begin
    logic       ack;
    logic [7:0] d;
    int         cv0, oe0;
    bus.scl = 1'b1;
    mag_x = 12'hABC; mag_y = 12'h123; mag_z = 12'h456; temp = 12'h789;
    wq(5);
    chk("rst_sda_oe", bus.sda_oe, 0);
    chk("rst_config_data", config_data, 0);
    chk("rst_config_valid", config_valid, 0);
    chk("rst_frm", frm, 0);
    chk("rst_busy", busy, 0);
    reset_n = 1'b1;
    wq(5);

    do_read("rd7", 7, {56'hAB124570C33689, 32'h0});
    wq(4);
    chk("frm_after_rd7", frm, 1);
    chk("busy_idle", busy, 0);

    do_read("rd11", 11, 88'hAB124574C33689112233FF);
    chk("frm_after_rd11", frm, 2);

    cv0 = cv_cycles;
    i2c_start();
    send_byte(8'hBC, ack); chk("wr_addr_ack", ack, 1);
    send_byte(8'h00, ack); chk("wr_ack0", ack, 1);
    send_byte(8'h05, ack); chk("wr_ack1", ack, 1);
    send_byte(8'h80, ack); chk("wr_ack2", ack, 1);
    send_byte(8'h40, ack); chk("wr_ack3", ack, 1);
    i2c_stop();
    wq(4);
    chk("wr_config_data", config_data, 32'h40800500);
    chk("wr_config_valid_cycles", cv_cycles - cv0, 1);

    i2c_start();
    send_byte(8'hBD, ack); chk("snap_addr_ack", ack, 1);
    recv_byte(d, 1'b1); chk("snap_byte0", d, 8'hAB);
    recv_byte(d, 1'b1); chk("snap_byte1", d, 8'h12);
    mag_x = 12'h5A5;
    recv_byte(d, 1'b1); chk("snap_byte2", d, 8'h45);
    recv_byte(d, 1'b1); chk("snap_byte3", d, 8'h78);
    recv_byte(d, 1'b0); chk("snap_byte4", d, 8'hC3);
    i2c_stop();
    chk("frm_after_snap", frm, 3);
    do_read("newx", 5, {40'h5A12457C53, 48'h0});
    chk("frm_wrap", frm, 0);

    oe0 = oe_cycles;
    cv0 = cv_cycles;
    i2c_start();
    send_byte(8'hBA, ack);
    chk("wrong_addr_nack", ack, 0);
    chk("wrong_addr_oe_cycles", oe_cycles - oe0, 0);
    chk("wrong_addr_busy", busy, 0);
    i2c_stop();
    i2c_start();
    send_byte(8'hBC, ack); chk("abort_addr_ack", ack, 1);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    i2c_start();
    wq(10);
    chk("abort_busy", busy, 0);
    i2c_stop();
    wq(4);
    chk("abort_config_valid_cycles", cv_cycles - cv0, 0);
    chk("abort_config_data", config_data, 32'h40800500);

    do_read("pre_rst", 1, {8'h5A, 80'h0});
    chk("frm_pre_rst", frm, 1);
    i2c_start();
    send_byte(8'hBD, ack); chk("rst_rd_addr_ack", ack, 1);
    wq(Q); wq(Q); bus.scl = 1'b1; wq(Q);
    chk("rst_rd_drive_low", bus.sda_oe, 1);
    reset_n = 1'b0;
    #1;
    chk("rst_rd_release", bus.sda_oe, 0);
    wq(2);
    chk("rst_rd_frm", frm, 0);
    chk("rst_rd_busy", busy, 0);
    chk("rst_rd_config", config_data, 0);
    sda_drv = 1'b1;
    wq(Q);
    reset_n = 1'b1;
    wq(Q);
    do_read("post_rst", 1, {8'h5A, 80'h0});
    chk("frm_post_rst", frm, 1);

    chk("oe_change_while_scl_high", oe_bad, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/tlv493_i2c_responder.md
# tlv493_i2c_responder

I2C target that emulates a TLV493D 3-axis Hall sensor at 7-bit address 0x5E, giving the TLV493 controller a synthesizable bus partner for hardware-in-the-loop and simulation. It serves the 10-byte read map built from field values supplied by the fabric. It also accepts the controller's configuration writes and reports them upstream. It sits on the same open-drain SCL/SDA pair the controller drives, and observes SCL only.

## Interface
- I2C_ADDR, 7'h5E, target address matched against the address byte.
- FILTER_LEN, 3, clock cycles a synchronized SCL/SDA level must be stable before it is accepted.
- HOLD_CYCLES, 4, clock cycles after an accepted SCL fall before sda_oe may change.
- FACTORY, 24'h000000, read bytes 7..9 as {byte7, byte8, byte9}.
- clock  in  1  system clock; must be at least 20x the SCL rate.
- reset_n  in  1  asynchronous active-low reset.
- scl  in  1  bus SCL level.
- sda_in  in  1  bus SDA level.
- sda_oe  out  1  1 = pull SDA low, 0 = release.
- mag_x, mag_y, mag_z  in  12 each  field values to present.
- temp  in  12  temperature value to present.
- config_data  out  32  last written bytes; write byte k lands in [8k+7:8k].
- config_valid  out  1  one-cycle pulse after a STOP that ended a write of 1 or more data bytes.
- frm  out  2  frame counter, also reported in read byte 3.
- busy  out  1  high from an address-matched START until STOP, NACK-release, or repeated START.

## Operation
- Input conditioning: scl and sda_in each pass through a 2-FF synchronizer, then a FILTER_LEN stability filter. All events below use the filtered signals.
- START: SDA falls while SCL is high. STOP: SDA rises while SCL is high. Both are recognized in every state.
- States and transitions:
  - IDLE: entered on reset or STOP.
  - ADDR: entered on START; shifts 8 bits MSB-first on SCL rises.
  - On mismatch of bits[7:1] with I2C_ADDR: go to IGNORE with no ACK; leave IGNORE only on the next START or STOP.
  - On match: go to ADDR_ACK and drive ACK.
  - After ADDR_ACK with R/W=0: WRITE_BYTE; each byte is ACKed in WRITE_ACK.
  - After ADDR_ACK with R/W=1: READ_BYTE, then READ_ACK, where the controller's ACK bit is sampled.
  - Controller ACK: continue with the next byte.
  - Controller NACK: release SDA and go to IGNORE.
- Snapshot: on address match with R/W=1, mag_x, mag_y, mag_z and temp are copied to shadow registers. The whole frame is served from the shadow registers.
- Read map (index starts at 0 per transaction):
  - byte 0: X[11:4]
  - byte 1: Y[11:4]
  - byte 2: Z[11:4]
  - byte 3: {T[11:8], frm, 2'b00}
  - byte 4: {X[3:0], Y[3:0]}
  - byte 5: {1'b0, 1'b0 (T), 1'b1 (FF), 1'b1 (PD), Z[3:0]}
  - byte 6: T[7:0]
  - bytes 7..9: FACTORY
  - index 10 and above: 8'hFF
- frm increments (mod 4) when a read transaction that transferred at least one byte ends by STOP or repeated START.
- Writes: byte k (k < 4) overwrites config_data[8k+7:8k]. Bytes 0..k-1 are replaced; unwritten bytes keep their old value. Bytes with k ≥ 4 are ACKed and discarded.
- Repeated START mid-transfer: the current transfer is aborted; no config_valid is issued for an aborted write; go to ADDR.

## Timing
- Reset values: sda_oe=0, config_data=0, config_valid=0, frm=0, busy=0, state=IDLE. Reset asserted mid-transfer releases SDA immediately.
- sda_oe changes only HOLD_CYCLES after an accepted SCL fall. It is never changed while filtered SCL is high.
- Received bits are sampled on the accepted SCL rise.
- ACK: sda_oe=1 from the ninth-bit SCL fall plus HOLD_CYCLES until the following SCL fall plus HOLD_CYCLES.
- Read data is driven MSB-first; sda_oe = ~bit.
- config_valid is asserted exactly one cycle, 1 cycle after the STOP is detected.
- busy rises 1 cycle after the address-match decision. It falls on STOP, on NACK-release, or on repeated START.

## Test plan
- Read 7 bytes at 0x5E with X=12'hABC, Y=12'h123, Z=12'h456, T=12'h789, after reset -> bytes AB 12 45 70 C3 36 89; frm becomes 1.
- Read 10 bytes with FACTORY=24'h112233 -> bytes 7..9 are 11 22 33; a read of 11 bytes returns FF at byte 10.
- Write 4 bytes 00 05 80 40 then STOP -> config_data=32'h40800500 and a single config_valid pulse.
- Change X mid-read -> the frame still returns the snapshot values; the next frame returns the new values.
- Address 0x5D; then an 0x5E write aborted by repeated START -> no ACK, sda_oe stays 0, and no config_valid in either case.
- reset_n low during a read data bit that is driving low -> sda_oe=0 immediately; frm=0 after release.
